edge_frame_buffer: RTL

Parametrised frame store between the edge-detection stage and the downstream OR-combine logic. Pixels arrive out of order with an explicit address and are written, or OR-accumulated, into a DEPTH-entry memory. On command, the whole frame streams out in address order over a valid/ready interface, with last-word and completion flags. It replaces the fixed 1-bit, 22500-entry, two-mode buffer with configurable width and depth, a handshaked read port and range checking.

---
 rtl/edge_frame_buffer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/edge_frame_buffer.sv
// Addressed frame store with write/OR-accumulate and a valid/ready in-order readout.
// Optional build macro: CLEAR_ON_READ_EN zeroes each location as it is fetched during a stream.
module edge_frame_buffer #(
    parameter int DATA_W = 1,
    parameter int DEPTH  = 22500,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enb,
    input  logic              wr_en,
    input  logic              wr_or,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start_read,
    input  logic              clear_done,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              rd_last,
    output logic              busy,
    output logic              complete,
    output logic              wr_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_r;
    logic [ADDR_W-1:0] ptr_r;
    logic              fetch_done_r;
    logic              q_valid_r;
    logic              q_last_r;
    logic [DATA_W-1:0] mem_q_r;
    logic [DATA_W-1:0] mem_r [DEPTH];

    logic wr_accept_s;
    logic hs_s;
    logic last_hs_s;
    logic load_s;
    logic fetch_s;

    // Write acceptance plus the fetch/load decisions of the two-stage read pipeline
    always_comb begin
        wr_accept_s = 1'b0;
        hs_s        = 1'b0;
        last_hs_s   = 1'b0;
        load_s      = 1'b0;
        fetch_s     = 1'b0;
        if (enb) begin
            wr_accept_s = wr_en && ({1'b0, wr_addr} < DEPTH_L) && (state_r != READ);
            if (state_r == READ) begin
                hs_s      = rd_valid && rd_ready;
                last_hs_s = hs_s && rd_last;
                load_s    = q_valid_r && (!rd_valid || hs_s);
                fetch_s   = !fetch_done_r && (!q_valid_r || load_s);
            end else begin
                hs_s      = 1'b0;
                last_hs_s = 1'b0;
                load_s    = 1'b0;
                fetch_s   = 1'b0;
            end
        end else begin
            wr_accept_s = 1'b0;
            hs_s        = 1'b0;
        end
    end

    // Frame memory: writes, optional clear-on-fetch, and the synchronous read register
    always_ff @(posedge clk) begin
        if (wr_accept_s) begin
            if (wr_or) begin
                mem_r[wr_addr] <= mem_r[wr_addr] | wr_data;
            end else begin
                mem_r[wr_addr] <= wr_data;
            end
        end
`ifdef CLEAR_ON_READ_EN
        else if (fetch_s) begin
            mem_r[ptr_r] <= {DATA_W{1'b0}};
        end
`endif
        if (fetch_s) begin
            mem_q_r <= mem_r[ptr_r];
        end
    end

    // Control FSM, read pointer, pipeline flags and all registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            ptr_r        <= {ADDR_W{1'b0}};
            fetch_done_r <= 1'b0;
            q_valid_r    <= 1'b0;
            q_last_r     <= 1'b0;
            rd_data      <= {DATA_W{1'b0}};
            rd_valid     <= 1'b0;
            rd_last      <= 1'b0;
            busy         <= 1'b0;
            complete     <= 1'b0;
            wr_err       <= 1'b0;
        end else if (enb) begin
            wr_err <= wr_en && !wr_accept_s;
            case (state_r)
                IDLE: begin
                    if (start_read) begin
                        state_r      <= READ;
                        busy         <= 1'b1;
                        ptr_r        <= {ADDR_W{1'b0}};
                        fetch_done_r <= 1'b0;
                        q_valid_r    <= 1'b0;
                    end
                end
                READ: begin
                    if (fetch_s) begin
                        q_valid_r <= 1'b1;
                        q_last_r  <= (ptr_r == LAST_ADDR);
                        if (ptr_r == LAST_ADDR) begin
                            fetch_done_r <= 1'b1;
                        end else begin
                            ptr_r <= ptr_r + ADDR_W'(1);
                        end
                    end else if (load_s) begin
                        q_valid_r <= 1'b0;
                    end
                    // The final word's handshake closes the stream at the same edge
                    if (last_hs_s) begin
                        state_r  <= DONE;
                        busy     <= 1'b0;
                        complete <= 1'b1;
                        rd_valid <= 1'b0;
                        rd_last  <= 1'b0;
                    end else if (load_s) begin
                        rd_data  <= mem_q_r;
                        rd_valid <= 1'b1;
                        rd_last  <= q_last_r;
                    end else if (hs_s) begin
                        rd_valid <= 1'b0;
                        rd_last  <= 1'b0;
                    end
                end
                DONE: begin
                    if (start_read) begin
                        state_r      <= READ;
                        busy         <= 1'b1;
                        complete     <= 1'b0;
                        ptr_r        <= {ADDR_W{1'b0}};
                        fetch_done_r <= 1'b0;
                        q_valid_r    <= 1'b0;
                    end else if (clear_done) begin
                        state_r  <= IDLE;
                        complete <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    busy      <= 1'b0;
                    complete  <= 1'b0;
                    rd_valid  <= 1'b0;
                    rd_last   <= 1'b0;
                    q_valid_r <= 1'b0;
                end
            endcase
        end else begin
            wr_err <= 1'b0;
        end
    end

endmodule
